// File: rtl/game_pkg.sv
//==========================================================================
// game_pkg - shared screen/sprite constants and blink FSM encoding. rev 1.0
//==========================================================================
`default_nettype none

package game_pkg;

  localparam int          H_MAX       = 640;
  localparam int          V_MAX       = 480;
  localparam int          SPRITE_SIZE = 16;
  localparam logic [7:0]  TRANSPARENT = 8'b10111011;

  typedef enum logic [0:0] {
    ALIVE = 1'b0,
    BLINK = 1'b1
  } blink_state_t;

  // One axis step: dec/inc move by vel, clamped to [0, lim]; 11-bit math avoids wrap.
  function automatic logic [9:0] step_axis(input logic [9:0]  pos,
                                           input logic        dec,
                                           input logic        inc,
                                           input logic [10:0] vel,
                                           input logic [9:0]  lim);
    logic [10:0] p11;
    logic [10:0] sum;
    p11       = {1'b0, pos};
    sum       = p11 + vel;
    step_axis = pos;
    if (dec && !inc) begin
      step_axis = (p11 >= vel) ? 10'(p11 - vel) : 10'd0;
    end else if (inc && !dec) begin
      step_axis = (sum > {1'b0, lim}) ? lim : sum[9:0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_mover.sv
//==========================================================================
// sprite_mover - per-frame button-driven sprite position with edge clamp. rev 1.0
//==========================================================================
`default_nettype none

module sprite_mover
  import game_pkg::*;
#(
  parameter int H_MAX       = game_pkg::H_MAX,
  parameter int V_MAX       = game_pkg::V_MAX,
  parameter int SPRITE_SIZE = game_pkg::SPRITE_SIZE,
  parameter int VELOCITY    = 2,
  parameter int START_X     = 312,
  parameter int START_Y     = 440
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y
);

  localparam logic [10:0] VEL   = 11'(VELOCITY);
  localparam logic [9:0]  X_LIM = 10'(H_MAX - SPRITE_SIZE);
  localparam logic [9:0]  Y_LIM = 10'(V_MAX - SPRITE_SIZE);

  // Position only moves on frame_tick so it is stable for a whole frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x <= 10'(START_X);
      pos_y <= 10'(START_Y);
    end else if (frame_tick) begin
      pos_x <= step_axis(pos_x, btn_left, btn_right, VEL, X_LIM);
      pos_y <= step_axis(pos_y, btn_up,   btn_down,  VEL, Y_LIM);
    end
  end

endmodule

`default_nettype wire

// File: rtl/player_sprite_renderer.sv
//==========================================================================
// player_sprite_renderer - sprite ROM address/colour pipeline and hit blink FSM. rev 1.0
//==========================================================================
`default_nettype none

module player_sprite_renderer
  import game_pkg::*;
#(
  parameter int         H_MAX        = game_pkg::H_MAX,
  parameter int         V_MAX        = game_pkg::V_MAX,
  parameter int         SPRITE_SIZE  = game_pkg::SPRITE_SIZE,
  parameter int         VELOCITY     = 2,
  parameter int         START_X      = 312,
  parameter int         START_Y      = 440,
  parameter logic [7:0] TRANSPARENT  = game_pkg::TRANSPARENT,
  parameter int         BLINK_FRAMES = 64,
  parameter int         BLINK_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       hit,
  output logic [3:0] rom_row,
  output logic [3:0] rom_col,
  input  logic [7:0] rom_data,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic       sprite_on,
  output logic [7:0] rgb,
  output logic       invuln
);

  localparam int             CNT_W     = $clog2(BLINK_FRAMES);
  localparam int             BLINK_BIT = $clog2(BLINK_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [10:0]    SZ        = 11'(SPRITE_SIZE);

  sprite_mover #(
    .H_MAX       (H_MAX),
    .V_MAX       (V_MAX),
    .SPRITE_SIZE (SPRITE_SIZE),
    .VELOCITY    (VELOCITY),
    .START_X     (START_X),
    .START_Y     (START_Y)
  ) u_mover (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .pos_x      (player_x),
    .pos_y      (player_y)
  );

  // Stage 0: box test and ROM address
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_box;

  assign dx      = {1'b0, pixel_x} - {1'b0, player_x};
  assign dy      = {1'b0, pixel_y} - {1'b0, player_y};
  assign in_box  = video_on && (pixel_x >= player_x) && (dx < SZ)
                            && (pixel_y >= player_y) && (dy < SZ);
  assign rom_col = dx[3:0];
  assign rom_row = dy[3:0];

  // Blink FSM
  blink_state_t     state, state_nxt;
  logic [CNT_W-1:0] frame_cnt, cnt_nxt;
  logic             visible;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ALIVE;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = frame_cnt;
    case (state)
      ALIVE: begin
        if (hit) begin
          state_nxt = BLINK;
          cnt_nxt   = '0;
        end
      end
      BLINK: begin
        if (frame_tick) begin
          if (frame_cnt == CNT_LAST) begin
            state_nxt = ALIVE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = frame_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ALIVE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign invuln  = (state == BLINK);
  assign visible = (state == ALIVE) || !frame_cnt[BLINK_BIT];

  // Stages 1-2: align box flag with ROM data, then register the pixel
  logic in_box_d1;
  logic opaque;

  assign opaque = in_box_d1 && visible && (rom_data != TRANSPARENT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_box_d1 <= 1'b0;
      sprite_on <= 1'b0;
      rgb       <= '0;
    end else begin
      in_box_d1 <= in_box;
      sprite_on <= opaque;
      rgb       <= opaque ? rom_data : 8'h00;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_player_sprite_renderer.sv
//==========================================================================
// tb_player_sprite_renderer - directed vector bench for player_sprite_renderer. rev 1.0
//==========================================================================
`default_nettype none

module tb_player_sprite_renderer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, frame_tick;
  logic       btn_left, btn_right, btn_up, btn_down, hit;
  logic [3:0] rom_row, rom_col;
  logic [7:0] rom_data;
  logic [9:0] player_x, player_y;
  logic       sprite_on;
  logic [7:0] rgb;
  logic       invuln;

  int n_checks = 0;
  int n_fail   = 0;
  int mx, my;

  player_sprite_renderer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .hit        (hit),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_data   (rom_data),
    .player_x   (player_x),
    .player_y   (player_y),
    .sprite_on  (sprite_on),
    .rgb        (rgb),
    .invuln     (invuln)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       vo;
    logic [7:0] data;
    logic       chk_addr;
    logic [3:0] row;
    logic [3:0] col;
    logic       on;
    logic [7:0] rgb;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic with_hit);
    @(negedge clk);
    frame_tick = 1'b1;
    hit        = with_hit;
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    hit        = 1'b0;
  endtask

  task automatic pulse_hit();
    @(negedge clk);
    hit = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hit = 1'b0;
  endtask

  // Address at cycle 0, ROM colour one cycle later, pixel out two clocks after address.
  task automatic scan(input string nm, input logic [9:0] x, input logic [9:0] y, input logic vo,
                      input logic [7:0] data, input logic chk_addr, input logic [3:0] erow,
                      input logic [3:0] ecol, input logic eon, input logic [7:0] ergb);
    @(negedge clk);
    pixel_x  = x;
    pixel_y  = y;
    video_on = vo;
    #1;
    if (chk_addr) begin
      check({nm, " rom_row"}, 32'(rom_row), 32'(erow));
      check({nm, " rom_col"}, 32'(rom_col), 32'(ecol));
    end
    @(posedge clk);
    @(negedge clk);
    video_on = 1'b0;
    rom_data = data;
    @(posedge clk);
    @(negedge clk);
    check({nm, " sprite_on"}, 32'(sprite_on), 32'(eon));
    check({nm, " rgb"},       32'(rgb),       32'(ergb));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic vis;
    //             x    y    vo  data   addr row   col   on    rgb
    vecs[0] = '{10'd312, 10'd440, 1'b1, 8'hBB, 1'b1, 4'd0,  4'd0,  1'b0, 8'h00};
    vecs[1] = '{10'd319, 10'd440, 1'b1, 8'hFF, 1'b1, 4'd0,  4'd7,  1'b1, 8'hFF};
    vecs[2] = '{10'd328, 10'd440, 1'b1, 8'hFF, 1'b0, 4'd0,  4'd0,  1'b0, 8'h00};
    vecs[3] = '{10'd327, 10'd455, 1'b1, 8'h12, 1'b1, 4'd15, 4'd15, 1'b1, 8'h12};
    vecs[4] = '{10'd311, 10'd440, 1'b1, 8'hFF, 1'b0, 4'd0,  4'd0,  1'b0, 8'h00};
    vecs[5] = '{10'd320, 10'd456, 1'b1, 8'hFF, 1'b0, 4'd0,  4'd0,  1'b0, 8'h00};
    vecs[6] = '{10'd315, 10'd445, 1'b0, 8'hFF, 1'b1, 4'd5,  4'd3,  1'b0, 8'h00};
    vecs[7] = '{10'd312, 10'd439, 1'b1, 8'hFF, 1'b0, 4'd0,  4'd0,  1'b0, 8'h00};
    vecs[8] = '{10'd320, 10'd447, 1'b1, 8'h00, 1'b1, 4'd7,  4'd8,  1'b1, 8'h00};

    reset_n = 1'b0; pixel_x = '0; pixel_y = '0; video_on = 1'b0; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0; hit = 1'b0;
    rom_data = 8'h00;
    #12;
    check("reset player_x", 32'(player_x), 32'd312);
    check("reset player_y", 32'(player_y), 32'd440);
    check("reset invuln", 32'(invuln), 32'd0);
    check("reset sprite_on", 32'(sprite_on), 32'd0);
    check("reset rgb", 32'(rgb), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) tick(1'b0);
    check("idle player_x", 32'(player_x), 32'd312);
    check("idle player_y", 32'(player_y), 32'd440);
    check("idle invuln", 32'(invuln), 32'd0);

    for (int i = 0; i < 9; i++)
      scan($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].vo, vecs[i].data,
           vecs[i].chk_addr, vecs[i].row, vecs[i].col, vecs[i].on, vecs[i].rgb);

    // Movement with clamping
    mx = 312; my = 440;
    btn_left = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick(1'b0);
      mx = (mx >= 2) ? mx - 2 : 0;
      check($sformatf("left x t%0d", i), 32'(player_x), 32'(mx));
    end
    check("left y", 32'(player_y), 32'(my));
    btn_right = 1'b1;
    tick(1'b0);
    check("left+right x", 32'(player_x), 32'd0);
    btn_left = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1'b0);
      mx = (mx + 2 > 624) ? 624 : mx + 2;
      check($sformatf("right x t%0d", i), 32'(player_x), 32'(mx));
    end
    btn_right = 1'b0;
    btn_down  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      my = (my + 2 > 464) ? 464 : my + 2;
      check($sformatf("down y t%0d", i), 32'(player_y), 32'(my));
    end
    btn_down = 1'b0;
    btn_up   = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0);
    my = my - 6;
    check("up y", 32'(player_y), 32'(my));
    btn_down = 1'b1;
    tick(1'b0);
    check("up+down y", 32'(player_y), 32'(my));
    btn_up = 1'b0; btn_down = 1'b0;

    // Blink after a hit; second hit at tick 10 must not extend it
    pulse_hit();
    check("hit invuln", 32'(invuln), 32'd1);
    for (int t = 0; t < 64; t++) begin
      if (t == 10) pulse_hit();
      vis = (((t >> 2) & 1) == 0);
      scan($sformatf("blink f%0d", t), 10'(mx + 3), 10'(my + 2), 1'b1, 8'h55, 1'b1,
           4'd2, 4'd3, vis, vis ? 8'h55 : 8'h00);
      check($sformatf("blink invuln f%0d", t), 32'(invuln), 32'd1);
      tick(1'b0);
    end
    check("blink end invuln", 32'(invuln), 32'd0);
    scan("alive again", 10'(mx), 10'(my), 1'b1, 8'h6A, 1'b1, 4'd0, 4'd0, 1'b1, 8'h6A);

    // Hit and frame_tick together: tick not counted, movement still applies
    btn_left = 1'b1;
    tick(1'b1);
    btn_left = 1'b0;
    mx = mx - 2;
    check("hit+tick invuln", 32'(invuln), 32'd1);
    check("hit+tick x", 32'(player_x), 32'(mx));
    for (int i = 0; i < 3; i++) tick(1'b0);
    scan("hit+tick f3", 10'(mx), 10'(my), 1'b1, 8'h77, 1'b1, 4'd0, 4'd0, 1'b1, 8'h77);
    tick(1'b0);
    scan("hit+tick f4", 10'(mx), 10'(my), 1'b1, 8'h77, 1'b1, 4'd0, 4'd0, 1'b0, 8'h00);
    for (int i = 0; i < 59; i++) tick(1'b0);
    check("hit+tick f63 invuln", 32'(invuln), 32'd1);
    tick(1'b0);
    check("hit+tick end invuln", 32'(invuln), 32'd0);

    // Asynchronous reset while a sprite pixel is showing
    @(negedge clk);
    pixel_x = 10'(mx + 1); pixel_y = 10'(my + 1); video_on = 1'b1;
    @(posedge clk);
    @(negedge clk);
    video_on = 1'b0; rom_data = 8'hE0;
    @(posedge clk);
    @(negedge clk);
    check("pre-reset sprite_on", 32'(sprite_on), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async sprite_on", 32'(sprite_on), 32'd0);
    check("async rgb", 32'(rgb), 32'd0);
    check("async player_x", 32'(player_x), 32'd312);
    check("async player_y", 32'(player_y), 32'd440);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post-reset rgb", 32'(rgb), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/player_sprite_renderer.md
Name: player_sprite_renderer

Overview:
- Drives pixel address into the 16x16 player sprite ROM and consumes its 8-bit RRRGGGBB colour output, with one-cycle registered-address latency.
- Owns the player position register, updated once per frame from buttons, and a hit/invulnerability blink FSM.
- Emits the pipelined sprite pixel (rgb, sprite_on) to the top-level VGA colour mux.

Parameters:
- H_MAX, 640, visible width in pixels
- V_MAX, 480, visible height in pixels
- SPRITE_SIZE, 16, sprite edge in pixels; ROM row/col are 4 bits
- VELOCITY, 2, pixels moved per frame_tick
- START_X, 312, reset x of the sprite's top-left corner
- START_Y, 440, reset y of the sprite's top-left corner
- TRANSPARENT, 8'b10111011, ROM colour treated as see-through
- BLINK_FRAMES, 64, frames of invulnerability after a hit
- BLINK_PERIOD, 4, frames per visibility half-cycle; must be a power of 2

Ports:
- clk  in  1  system/pixel clock
- reset_n  in  1  asynchronous active-low reset
- pixel_x  in  10  current scan x from VGA sync
- pixel_y  in  10  current scan y from VGA sync
- video_on  in  1  scan inside the visible area
- frame_tick  in  1  one-cycle pulse at start of vblank
- btn_left, btn_right, btn_up, btn_down  in  1 each  debounced button levels
- hit  in  1  one-cycle collision pulse from the enemy/bullet logic
- rom_row  out  4  sprite ROM row address
- rom_col  out  4  sprite ROM column address
- rom_data  in  8  sprite ROM colour, valid one cycle after address
- player_x  out  10  sprite top-left x
- player_y  out  10  sprite top-left y
- sprite_on  out  1  opaque, visible sprite pixel at the aligned scan position
- rgb  out  8  sprite colour when sprite_on, else 0
- invuln  out  1  high while in BLINK

Behaviour:
- Reset (async, reset_n=0):
  - player_x=START_X, player_y=START_Y
  - FSM=ALIVE, frame_cnt=0
  - pipeline flags=0, sprite_on=0, rgb=0, invuln=0
- Address path (stage 0, combinational):
  - in_box = video_on & pixel_x in [player_x, player_x+SPRITE_SIZE-1] & pixel_y in [player_y, player_y+SPRITE_SIZE-1]
  - rom_col = (pixel_x-player_x)[3:0], rom_row = (pixel_y-player_y)[3:0]
  - Addresses are don't-care outside the box.
- Stage 1 (register): in_box_d1 <= in_box.
- Stage 2 (register):
  - sprite_on <= in_box_d1 & visible & (rom_data != TRANSPARENT)
  - rgb <= that condition ? rom_data : 0
- Total latency from pixel_x/pixel_y to rgb/sprite_on is 2 clocks; the top-level mux delays its other layers to match.
- Movement (only on frame_tick, so position never changes mid-frame):
  - left&!right: x = max(x-VELOCITY, 0)
  - right&!left: x = min(x+VELOCITY, H_MAX-SIZE)
  - Both or neither pressed: x unchanged.
  - y axis uses up/down the same way, clamped to [0, V_MAX-SIZE].
  - Clamp arithmetic uses 11-bit intermediates; no wrap-around.
- FSM:
  - ALIVE: hit -> BLINK, frame_cnt=0.
  - BLINK: frame_tick -> frame_cnt+1. At frame_tick with frame_cnt==BLINK_FRAMES-1 -> ALIVE, frame_cnt=0.
  - hit while in BLINK is ignored; the counter is not restarted.
  - hit and frame_tick in the same cycle from ALIVE: enter BLINK with frame_cnt=0; that tick is not counted. Movement still applies.
  - invuln = (state==BLINK), registered with the state.
  - visible = ALIVE, or BLINK with frame_cnt[log2(BLINK_PERIOD)]==0.
  - Sprite is therefore visible for BLINK frames 0-3, hidden for 4-7, and so on.
- Reset mid-frame clears the pipeline immediately; the next output is rgb=0.

Decomposition:
- Shared package `game_pkg`:
  - colour constants TRANSPARENT, H_MAX, V_MAX, SPRITE_SIZE
  - FSM state encoding {ALIVE, BLINK}, 1 bit
- One sub-module: `sprite_mover` holds player_x/player_y and the clamp logic, reused by future enemy sprites.
- The FSM and the render pipeline stay in the top of this block.

Test Plan:
- Reset, then hold all buttons low for 3 frame_ticks -> player_x=312, player_y=440, invuln=0.
- Scan pixel (312,440) with video_on=1 and rom_data=8'hBB one cycle later -> sprite_on=0, rgb=0 two clocks after the address.
- Scan (319,440) with rom_data=8'hFF -> rom_row=0, rom_col=7; two clocks later sprite_on=1, rgb=8'hFF. Scan (328,440) -> sprite_on=0.
- Hold btn_left for 200 frame_ticks -> player_x steps by 2 per tick down to 0 and stays 0. Then press left+right together -> no change.
- Pulse hit, then issue 64 frame_ticks with an opaque ROM colour:
  - invuln=1 during ticks 0-63, sprite hidden during frames 4-7, 12-15, ...
  - invuln=0 after the 64th tick.
  - A second hit at tick 10 does not extend the blink.
- Assert reset_n=0 asynchronously mid-scanline while sprite_on=1 -> sprite_on/rgb drop to 0 without waiting for a clock edge, and position returns to (312,440).
